// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_pipe_reg
//  Purpose  : ID/EX pipeline register of the pipelined MIPS core. Latches the
//             packed 39-bit decoder control word plus PC/operands/immediate,
//             presents the control fields unpacked to EX, detects load-use
//             hazards (one bubble + decode stall), honours ex_stall and flush.
//  Config   : ID_EX_HAZARD_EN - when defined, builds load-use detection,
//             hazard bubbles and the saturating bubble counter. When not
//             defined, hz is tied low, id_stall = ex_stall, bubble_cnt = 0.
//  Ports    : clk, rst_n (async, active-low)
//             id_ctrl[38:0], id_valid, id_pc/id_a/id_b/id_imm [DATA_W-1:0]
//             ex_stall, flush                 - pipeline control in
//             id_stall                        - combinational decode hold
//             ex_valid, ex_<field>, ex_pc/a/b/imm - registered EX slot
//             bubble_cnt[CNT_W-1:0]           - saturating hazard bubble count
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [38:0]       id_ctrl,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_a,
  input  logic [DATA_W-1:0] id_b,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [3:0]        ex_af,
  output logic              ex_i,
  output logic              ex_alu_mux_sel,
  output logic [2:0]        ex_shift_type,
  output logic [4:0]        ex_cad,
  output logic              ex_gp_we,
  output logic [1:0]        ex_gp_mux_sel,
  output logic [3:0]        ex_bf,
  output logic [1:0]        ex_pc_mux_select,
  output logic              ex_mem_wren,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0] c_GP_MUX_LOAD = 2'b01;

  logic              r_valid;
  logic [38:0]       r_ctrl;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_imm;
  logic              w_hz;

`ifdef ID_EX_HAZARD_EN
  logic [CNT_W-1:0]  r_cnt;

  // EX holds a valid load writing a non-zero register that the decode-stage
  // instruction reads through rs or rt.
  assign w_hz = r_valid & r_ctrl[24] & (r_ctrl[23:22] == c_GP_MUX_LOAD)
              & (r_ctrl[29:25] != 5'd0) & id_valid
              & ((r_ctrl[29:25] == id_ctrl[9:5]) | (r_ctrl[29:25] == id_ctrl[4:0]));

  // Counts only when the hazard bubble is actually loaded (not on flush or
  // stall cycles), saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!flush && !ex_stall && w_hz && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bubble_cnt = r_cnt;
`else
  assign w_hz       = 1'b0;
  assign bubble_cnt = '0;
`endif

  // A hazard stall is pointless when the decode instruction is being killed.
  assign id_stall = ex_stall | (w_hz & ~flush);

  // A bubble zeroes the whole slot, so it carries no side effects at all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_pc    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
    end else if (flush || (!ex_stall && w_hz)) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_pc    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
    end else if (!ex_stall) begin
      r_valid <= id_valid;
      r_ctrl  <= id_ctrl;
      r_pc    <= id_pc;
      r_a     <= id_a;
      r_b     <= id_b;
      r_imm   <= id_imm;
    end
  end

  assign ex_valid         = r_valid;
  assign ex_af            = r_ctrl[38:35];
  assign ex_i             = r_ctrl[34];
  assign ex_alu_mux_sel   = r_ctrl[33];
  assign ex_shift_type    = r_ctrl[32:30];
  assign ex_cad           = r_ctrl[29:25];
  assign ex_gp_we         = r_ctrl[24];
  assign ex_gp_mux_sel    = r_ctrl[23:22];
  assign ex_bf            = r_ctrl[21:18];
  assign ex_pc_mux_select = r_ctrl[17:16];
  assign ex_mem_wren      = r_ctrl[15];
  assign ex_rd            = r_ctrl[14:10];
  assign ex_rs            = r_ctrl[9:5];
  assign ex_rt            = r_ctrl[4:0];
  assign ex_pc            = r_pc;
  assign ex_a             = r_a;
  assign ex_b             = r_b;
  assign ex_imm           = r_imm;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_pipe_reg
//  Purpose  : Self-checking bench for id_ex_pipe_reg. Directed scenarios plus
//             random traffic compared against a slot-level reference model.
//             A 4-bit counter instance keeps saturation reachable quickly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;

  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef ID_EX_HAZARD_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [38:0]   id_ctrl;
  logic          id_valid;
  logic [DW-1:0] id_pc, id_a, id_b, id_imm;
  logic          ex_stall, flush;
  logic          id_stall, ex_valid;
  logic [3:0]    ex_af;
  logic          ex_i, ex_alu_mux_sel;
  logic [2:0]    ex_shift_type;
  logic [4:0]    ex_cad;
  logic          ex_gp_we;
  logic [1:0]    ex_gp_mux_sel;
  logic [3:0]    ex_bf;
  logic [1:0]    ex_pc_mux_select;
  logic          ex_mem_wren;
  logic [4:0]    ex_rd, ex_rs, ex_rt;
  logic [DW-1:0] ex_pc, ex_a, ex_b, ex_imm;
  logic [CW-1:0] bubble_cnt;

  id_ex_pipe_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .id_pc(id_pc), .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
    .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_af(ex_af), .ex_i(ex_i), .ex_alu_mux_sel(ex_alu_mux_sel),
    .ex_shift_type(ex_shift_type), .ex_cad(ex_cad), .ex_gp_we(ex_gp_we),
    .ex_gp_mux_sel(ex_gp_mux_sel), .ex_bf(ex_bf), .ex_pc_mux_select(ex_pc_mux_select),
    .ex_mem_wren(ex_mem_wren), .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: contents of the EX slot and the bubble count.
  logic          m_valid;
  logic [38:0]   m_ctrl;
  logic [DW-1:0] m_pc, m_a, m_b, m_imm;
  int            m_cnt;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [38:0] mk(input logic [3:0] af, input logic [4:0] cad,
                                     input logic we, input logic [1:0] gpm,
                                     input logic [4:0] rs, input logic [4:0] rt);
    // i=0, alu_sel=1, shift=3'b010, bf=4'h5, pc_mux=2'b00, mem_wren=0, rd=5'd7
    return {af, 1'b0, 1'b1, 3'b010, cad, we, gpm, 4'h5, 2'b00, 1'b0, 5'd7, rs, rt};
  endfunction

  function automatic bit model_hz();
    logic [4:0] cad;
    bool_calc: begin
      cad = m_ctrl[29:25];
    end
    return HZ_EN && m_valid && m_ctrl[24] && (m_ctrl[23:22] == 2'b01) && (cad != 5'd0)
           && id_valid && ((cad == id_ctrl[9:5]) || (cad == id_ctrl[4:0]));
  endfunction

  task automatic model_clear(input bit with_cnt);
    m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_a = '0; m_b = '0; m_imm = '0;
    if (with_cnt) m_cnt = 0;
  endtask

  task automatic check_slot();
    chk("ex_slot", {ex_valid, ex_af, ex_i, ex_alu_mux_sel, ex_shift_type, ex_cad, ex_gp_we,
                    ex_gp_mux_sel, ex_bf, ex_pc_mux_select, ex_mem_wren, ex_rd, ex_rs, ex_rt,
                    ex_pc, ex_a, ex_b, ex_imm},
                   {m_valid, m_ctrl, m_pc, m_a, m_b, m_imm});
    chk("bubble_cnt", bubble_cnt, m_cnt[CW-1:0]);
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    bit hz;
    if (!rst_n) model_clear(1'b1);
    hz = model_hz();
    chk("id_stall", id_stall, ex_stall | (hz & ~flush));
    @(posedge clk);
    if (!rst_n) begin
      model_clear(1'b1);
    end else if (flush) begin
      model_clear(1'b0);
    end else if (ex_stall) begin
      // hold
    end else if (hz) begin
      model_clear(1'b0);
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end else begin
      m_valid = id_valid; m_ctrl = id_ctrl;
      m_pc = id_pc; m_a = id_a; m_b = id_b; m_imm = id_imm;
    end
    #1;
    check_slot();
    @(negedge clk);
  endtask

  task automatic drive(input logic [38:0] c, input logic v);
    id_ctrl = c; id_valid = v; flush = 1'b0; ex_stall = 1'b0;
    id_pc = $urandom; id_a = $urandom; id_b = $urandom; id_imm = $urandom;
  endtask

  task automatic do_hazard();
    drive(mk(4'h1, 5'd8, 1'b1, 2'b01, 5'd0, 5'd0), 1'b1); tick();
    drive(mk(4'h2, 5'd4, 1'b0, 2'b00, 5'd9, 5'd8), 1'b1); tick(); tick();
  endtask

  logic [63:0] rnd;
  int          c0;

  initial begin
    rst_n = 1'b0;
    model_clear(1'b1);
    drive({$urandom, $urandom}, 1'b1);
    @(negedge clk);

    // Reset held with random inputs
    for (int n = 0; n < 3; n++) begin
      rnd = {$urandom, $urandom};
      drive(rnd[38:0], 1'(rnd[40]));
      ex_stall = rnd[41]; flush = rnd[42];
      tick();
      chk("reset_valid", ex_valid, 1'b0);
    end

    // First valid word after release
    rst_n = 1'b1;
    drive(39'h1_2345_6789, 1'b1);
    tick();
    chk("first_ctrl", {ex_af, ex_i, ex_alu_mux_sel, ex_shift_type, ex_cad, ex_gp_we,
                       ex_gp_mux_sel, ex_bf, ex_pc_mux_select, ex_mem_wren, ex_rd,
                       ex_rs, ex_rt}, 39'h1_2345_6789);
    chk("first_valid", ex_valid, 1'b1);

    // Passthrough
    drive(mk(4'hA, 5'd3, 1'b0, 2'b00, 5'd1, 5'd2), 1'b1);
    id_a = 32'hDEAD_BEEF;
    tick();
    chk("pt_af", ex_af, 4'hA);
    chk("pt_cad", ex_cad, 5'd3);
    chk("pt_a", ex_a, 32'hDEAD_BEEF);
    chk("pt_valid", ex_valid, 1'b1);

    // Load-use hazard
    c0 = m_cnt;
    drive(mk(4'h3, 5'd8, 1'b1, 2'b01, 5'd0, 5'd0), 1'b1); tick();
    drive(mk(4'h4, 5'd5, 1'b0, 2'b00, 5'd8, 5'd3), 1'b1);
    chk("lu_stall", id_stall, HZ_EN);
    tick();
    chk("lu_bubble", ex_valid, !HZ_EN);
    chk("lu_cnt", bubble_cnt, 4'(c0 + int'(HZ_EN)));
    tick();
    chk("lu_adv_valid", ex_valid, 1'b1);
    chk("lu_adv_rs", ex_rs, 5'd8);

    // Load to $0 never hazards
    c0 = m_cnt;
    drive(mk(4'h5, 5'd0, 1'b1, 2'b01, 5'd0, 5'd0), 1'b1); tick();
    drive(mk(4'h6, 5'd2, 1'b0, 2'b00, 5'd0, 5'd0), 1'b1);
    chk("cad0_stall", id_stall, 1'b0);
    tick();
    chk("cad0_cnt", bubble_cnt, 4'(c0));

    // Flush + hazard + ex_stall together
    drive(mk(4'h7, 5'd8, 1'b1, 2'b01, 5'd0, 5'd0), 1'b1); tick();
    c0 = m_cnt;
    drive(mk(4'h8, 5'd2, 1'b0, 2'b00, 5'd8, 5'd1), 1'b1);
    flush = 1'b1; ex_stall = 1'b1;
    chk("fhs_stall", id_stall, 1'b1);
    tick();
    chk("fhs_bubble", ex_valid, 1'b0);
    chk("fhs_cnt", bubble_cnt, 4'(c0));

    // Asynchronous reset in the middle of a stall
    drive(mk(4'h9, 5'd8, 1'b1, 2'b01, 5'd0, 5'd0), 1'b1); tick();
    drive(mk(4'hB, 5'd2, 1'b0, 2'b00, 5'd8, 5'd1), 1'b1); ex_stall = 1'b1; tick();
    #2 rst_n = 1'b0;
    #1 model_clear(1'b1);
    check_slot();
    @(negedge clk);
    tick();
    rst_n = 1'b1;

    // Saturation of the bubble counter
    for (int n = 0; n < CMAX + 3; n++) do_hazard();
    chk("sat_cnt", bubble_cnt, HZ_EN ? 4'(CMAX) : 4'd0);

    // Random traffic biased toward loads and register collisions
    for (int n = 0; n < 400; n++) begin
      rnd = {$urandom, $urandom};
      if (rnd[63]) begin rnd[24] = 1'b1; rnd[23:22] = 2'b01; end
      rnd[29:25] = 5'($urandom_range(0, 3));
      rnd[9:5]   = 5'($urandom_range(0, 3));
      rnd[4:0]   = 5'($urandom_range(0, 3));
      drive(rnd[38:0], $urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      ex_stall = ($urandom_range(0, 4) == 0);
      rst_n    = ($urandom_range(0, 79) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
